// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem word reads and buffers
// {instruction, pc} pairs for decode; handles redirects, stale-response drain and misaligned targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 2;

    typedef enum logic {
        RUN,
        FAULT
    } state_e;

    state_e         state_q;
    logic [31:0]    pc_q, pc_d;
    logic [CW-1:0]  occ_q, occ_d;
    logic [CW-1:0]  infl_q, infl_d;
    logic [CW-1:0]  disc_q, disc_d;
    logic [PW-1:0]  fifo_rd_q, fifo_wr_q;
    logic [PW-1:0]  pcq_rd_q, pcq_wr_q;
    logic [31:0]    fifo_data_q [DEPTH];
    logic [31:0]    fifo_pc_q   [DEPTH];
    logic [31:0]    pcq_q       [DEPTH];

    logic           pop;
    logic           req_fire;
    logic           rsp_keep;
    logic           rsp_drop;
    logic [SW-1:0]  used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_fault       = (state_q == FAULT);
    assign out_valid       = !redirect_valid && (out_fault || (occ_q != '0));
    assign out_instruction = out_fault ? 32'h0000_0000 : fifo_data_q[fifo_rd_q];
    assign out_pc          = out_fault ? pc_q : fifo_pc_q[fifo_rd_q];
    assign imem_addr       = pc_q;

    // Credit covers buffered, in-flight and still-draining stale slots; a same-cycle pop frees one.
    always_comb begin
        used           = SW'(occ_q) + SW'(infl_q) + SW'(disc_q);
        pop            = out_valid && out_ready && (state_q == RUN);
        imem_req_valid = rst_n && (state_q == RUN) && !redirect_valid
                         && (used < (SW'(DEPTH) + SW'(pop)));
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (disc_q != '0);
        rsp_keep       = imem_rsp_valid && (disc_q == '0) && !redirect_valid;
    end

    always_comb begin
        pc_d   = pc_q;
        occ_d  = occ_q;
        infl_d = infl_q;
        disc_d = disc_q;
        if (redirect_valid) begin
            // Everything still outstanding becomes stale, less any response landing now.
            pc_d   = redirect_pc;
            occ_d  = '0;
            infl_d = '0;
            disc_d = disc_q + infl_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            occ_d  = occ_q + CW'(rsp_keep) - CW'(pop);
            infl_d = infl_q + CW'(req_fire) - CW'(rsp_keep);
            disc_d = disc_q - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            occ_q       <= '0;
            infl_q      <= '0;
            disc_q      <= '0;
            fifo_rd_q   <= '0;
            fifo_wr_q   <= '0;
            pcq_rd_q    <= '0;
            pcq_wr_q    <= '0;
            fifo_data_q <= '{default: '0};
            fifo_pc_q   <= '{default: '0};
            pcq_q       <= '{default: '0};
        end else begin
            pc_q   <= pc_d;
            occ_q  <= occ_d;
            infl_q <= infl_d;
            disc_q <= disc_d;
            if (redirect_valid) begin
                state_q   <= (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
                fifo_rd_q <= '0;
                fifo_wr_q <= '0;
                pcq_rd_q  <= '0;
                pcq_wr_q  <= '0;
            end else begin
                if (req_fire) begin
                    pcq_q[pcq_wr_q] <= pc_q;
                    pcq_wr_q        <= ptr_inc(pcq_wr_q);
                end
                if (rsp_keep) begin
                    fifo_data_q[fifo_wr_q] <= imem_rsp_data;
                    fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
                    fifo_wr_q              <= ptr_inc(fifo_wr_q);
                    pcq_rd_q               <= ptr_inc(pcq_rd_q);
                end
                if (pop) begin
                    fifo_rd_q <= ptr_inc(fifo_rd_q);
                end
            end
        end
    end

    // Memory must never answer a request we did not issue.
    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> ((infl_q != '0) || (disc_q != '0)));

endmodule
